plane_vram_arbiter: RTL and testbench

Arbitrates the single-port foreground-plane VRAM between the display fetch path (which feeds the per-pixel plane logic) and the CPU access port. It sits between the plane's fetch sequencer and the VRAM macro, one command per clock. Display has priority. A starvation counter bounds CPU latency. Read data is routed back to its owner through an owner-tag pipeline matched to the VRAM read latency.

---
 rtl/plane_vram_arbiter_if.sv | 41 ++++
 rtl/plane_vram_arbiter.sv | 123 ++++++++++++
 tb/tb_plane_vram_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/plane_vram_arbiter_if.sv
// Bus bundle between the plane fetch sequencer, the CPU port and the VRAM macro.
// The arbiter takes the slave side; the surrounding system takes the master side.
interface plane_vram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_ack;
  logic [DATA_W-1:0] disp_rdata;
  logic              disp_valid;
  logic              disp_stall;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;

  logic              vram_en;
  logic              vram_we;
  logic [ADDR_W-1:0] vram_addr;
  logic [DATA_W-1:0] vram_wdata;
  logic [DATA_W-1:0] vram_rdata;

  modport slave (
    input  disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, vram_rdata,
    output disp_ack, disp_rdata, disp_valid, disp_stall,
           cpu_ack, cpu_rdata, cpu_rvalid,
           vram_en, vram_we, vram_addr, vram_wdata
  );

  modport master (
    output disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, vram_rdata,
    input  disp_ack, disp_rdata, disp_valid, disp_stall,
           cpu_ack, cpu_rdata, cpu_rvalid,
           vram_en, vram_we, vram_addr, vram_wdata
  );
endinterface

// File: rtl/plane_vram_arbiter.sv
// Single-port VRAM arbiter for the foreground plane: display fetch has priority,
// a saturating wait counter lets a starved CPU win one slot, and an owner-tag
// pipeline steers returning read data back to whoever issued the read.
module plane_vram_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int RD_LAT       = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  N_reset,
  plane_vram_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_CPU} tag_t;

  logic [7:0]        cpu_wait;
  logic              starve;
  logic              cpu_ack;
  logic              disp_ack;
  tag_t              tag_in;
  tag_t              tag_q [RD_LAT+1];

  logic              vram_en;
  logic              vram_we;
  logic [ADDR_W-1:0] vram_addr;
  logic [DATA_W-1:0] vram_wdata;
  logic [DATA_W-1:0] disp_rdata;
  logic              disp_valid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;
  logic              disp_stall;

  assign starve = (cpu_wait >= 8'(STARVE_LIMIT));

  // Grant: display wins unless the CPU has waited long enough to override it.
  always_comb begin
    cpu_ack  = 1'b0;
    disp_ack = 1'b0;
    cpu_ack  = bus.cpu_req && (!bus.disp_req || starve);
    disp_ack = bus.disp_req && !cpu_ack;
  end

  // Owner tag for the command being accepted this cycle; writes return nothing.
  always_comb begin
    tag_in = TAG_NONE;
    if (cpu_ack && !bus.cpu_we) tag_in = TAG_CPU;
    else if (disp_ack)          tag_in = TAG_DISP;
  end

  // Count consecutive denied CPU cycles, saturating so it never wraps back to 0.
  always_ff @(posedge clk or negedge N_reset) begin
    if (!N_reset)                   cpu_wait <= '0;
    else if (cpu_ack || !bus.cpu_req) cpu_wait <= '0;
    else if (cpu_wait != 8'hFF)     cpu_wait <= cpu_wait + 8'd1;
  end

  // Command register toward the VRAM; address/data hold when idle.
  always_ff @(posedge clk or negedge N_reset) begin
    if (!N_reset) begin
      vram_en    <= 1'b0;
      vram_we    <= 1'b0;
      vram_addr  <= '0;
      vram_wdata <= '0;
    end else if (cpu_ack) begin
      vram_en    <= 1'b1;
      vram_we    <= bus.cpu_we;
      vram_addr  <= bus.cpu_addr;
      vram_wdata <= bus.cpu_wdata;
    end else if (disp_ack) begin
      vram_en    <= 1'b1;
      vram_we    <= 1'b0;
      vram_addr  <= bus.disp_addr;
    end else begin
      vram_en    <= 1'b0;
      vram_we    <= 1'b0;
    end
  end

  // Tag pipeline: the last stage lines up with the cycle vram_rdata is valid.
  always_ff @(posedge clk or negedge N_reset) begin
    if (!N_reset) begin
      for (int i = 0; i <= RD_LAT; i++) tag_q[i] <= TAG_NONE;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i <= RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Capture returning read data into the owner's register and pulse its valid.
  always_ff @(posedge clk or negedge N_reset) begin
    if (!N_reset) begin
      disp_rdata <= '0;
      disp_valid <= 1'b0;
      cpu_rdata  <= '0;
      cpu_rvalid <= 1'b0;
    end else begin
      disp_valid <= (tag_q[RD_LAT] == TAG_DISP);
      cpu_rvalid <= (tag_q[RD_LAT] == TAG_CPU);
      if (tag_q[RD_LAT] == TAG_DISP) disp_rdata <= bus.vram_rdata;
      if (tag_q[RD_LAT] == TAG_CPU)  cpu_rdata  <= bus.vram_rdata;
    end
  end

  // Flag a display request that lost arbitration in the previous cycle.
  always_ff @(posedge clk or negedge N_reset) begin
    if (!N_reset) disp_stall <= 1'b0;
    else          disp_stall <= bus.disp_req && !disp_ack;
  end

  assign bus.cpu_ack    = cpu_ack;
  assign bus.disp_ack   = disp_ack;
  assign bus.vram_en    = vram_en;
  assign bus.vram_we    = vram_we;
  assign bus.vram_addr  = vram_addr;
  assign bus.vram_wdata = vram_wdata;
  assign bus.disp_rdata = disp_rdata;
  assign bus.disp_valid = disp_valid;
  assign bus.cpu_rdata  = cpu_rdata;
  assign bus.cpu_rvalid = cpu_rvalid;
  assign bus.disp_stall = disp_stall;

endmodule

// File: tb/tb_plane_vram_arbiter.sv
// Bench for plane_vram_arbiter: two instances (read latency 1 and 3) see the same
// request stream; a reference grant model predicts acks and read data, and each
// lane's scoreboard matches valid pulses against the predicted data and cycle.
module tb_plane_vram_arbiter;

  localparam int LIMIT = 8;

  typedef struct {
    logic [15:0] data;
    int          e;
  } exp_t;

  logic        clk = 1'b0;
  logic        N_reset = 1'b1;
  logic        disp_req = 1'b0;
  logic [15:0] disp_addr = '0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;

  int total_checks = 0;
  int bad_checks = 0;
  int cyc = 0;

  logic [7:0]  m_wait = '0;
  logic        exp_dack, exp_cack, exp_en, exp_we, exp_stall;
  logic [15:0] exp_addr, exp_wdata;
  logic        p_disp, p_cpu;
  logic [15:0] p_data;
  int          p_e;
  logic [15:0] tb_mem [logic [15:0]];

  event ack_ev, post_ev, push_ev, clr_ev, rst_ev, end_ev;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total_checks++;
    if (got !== want) begin
      bad_checks++;
      $display("[TB] FAIL %s got=%h want=%h at cycle %0d", tag, got, want, cyc);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [15:0] a);
    if (tb_mem.exists(a)) return tb_mem[a];
    return a ^ 16'hA5A5;
  endfunction

  genvar g;
  for (g = 0; g < 2; g++) begin : lane
    localparam int LAT = (g == 0) ? 1 : 3;

    plane_vram_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();
    logic [15:0] mem   [256];
    logic [15:0] rpipe [LAT];
    exp_t dq[$];
    exp_t cq[$];
    exp_t ent;

    assign bus.disp_req   = disp_req;
    assign bus.disp_addr  = disp_addr;
    assign bus.cpu_req    = cpu_req;
    assign bus.cpu_we     = cpu_we;
    assign bus.cpu_addr   = cpu_addr;
    assign bus.cpu_wdata  = cpu_wdata;
    assign bus.vram_rdata = rpipe[LAT-1];

    plane_vram_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(LAT), .STARVE_LIMIT(LIMIT)) dut (
      .clk     (clk),
      .N_reset (N_reset),
      .bus     (bus.slave)
    );

    // VRAM model: cells store data XOR the default pattern so a cleared cell reads addr^A5A5.
    always @(posedge clk) begin
      if (cyc == 0) begin
        for (int i = 0; i < 256; i++) mem[i] <= '0;
        for (int i = 0; i < LAT; i++) rpipe[i] <= '0;
      end else begin
        if (bus.vram_en && bus.vram_we)
          mem[bus.vram_addr[7:0]] <= bus.vram_wdata ^ bus.vram_addr ^ 16'hA5A5;
        for (int i = LAT - 1; i > 0; i--) rpipe[i] <= rpipe[i-1];
        rpipe[0] <= mem[bus.vram_addr[7:0]] ^ bus.vram_addr ^ 16'hA5A5;
      end
    end

    always @(push_ev) begin
      if (p_disp) dq.push_back('{p_data, p_e});
      if (p_cpu)  cq.push_back('{p_data, p_e});
    end

    always @(clr_ev) begin
      dq.delete();
      cq.delete();
    end

    always @(ack_ev) begin
      checkOutput($sformatf("lane%0d disp_ack", g), 32'(bus.disp_ack), 32'(exp_dack));
      checkOutput($sformatf("lane%0d cpu_ack", g), 32'(bus.cpu_ack), 32'(exp_cack));
    end

    always @(post_ev) begin
      checkOutput($sformatf("lane%0d vram_en", g), 32'(bus.vram_en), 32'(exp_en));
      checkOutput($sformatf("lane%0d vram_we", g), 32'(bus.vram_we), 32'(exp_we));
      checkOutput($sformatf("lane%0d disp_stall", g), 32'(bus.disp_stall), 32'(exp_stall));
      if (exp_en) checkOutput($sformatf("lane%0d vram_addr", g), 32'(bus.vram_addr), 32'(exp_addr));
      if (exp_we) checkOutput($sformatf("lane%0d vram_wdata", g), 32'(bus.vram_wdata), 32'(exp_wdata));
    end

    always @(rst_ev) begin
      checkOutput($sformatf("lane%0d rst vram", g),
                  {bus.vram_addr, 14'd0, bus.vram_en, bus.vram_we}, 32'd0);
      checkOutput($sformatf("lane%0d rst wdata", g), 32'(bus.vram_wdata), 32'd0);
      checkOutput($sformatf("lane%0d rst rdata", g), {bus.disp_rdata, bus.cpu_rdata}, 32'd0);
      checkOutput($sformatf("lane%0d rst flags", g),
                  {29'd0, bus.disp_valid, bus.cpu_rvalid, bus.disp_stall}, 32'd0);
    end

    // Scoreboard: every valid pulse must match the oldest outstanding read of its owner.
    always @(negedge clk) begin
      if (N_reset) begin
        if (bus.disp_valid) begin
          if (dq.size() == 0) checkOutput($sformatf("lane%0d disp_extra", g), 32'd1, 32'd0);
          else begin
            ent = dq.pop_front();
            checkOutput($sformatf("lane%0d disp_rdata", g), 32'(bus.disp_rdata), 32'(ent.data));
            checkOutput($sformatf("lane%0d disp_lat", g), 32'(cyc), 32'(ent.e + 1 + LAT));
          end
        end
        if (bus.cpu_rvalid) begin
          if (cq.size() == 0) checkOutput($sformatf("lane%0d cpu_extra", g), 32'd1, 32'd0);
          else begin
            ent = cq.pop_front();
            checkOutput($sformatf("lane%0d cpu_rdata", g), 32'(bus.cpu_rdata), 32'(ent.data));
            checkOutput($sformatf("lane%0d cpu_lat", g), 32'(cyc), 32'(ent.e + 1 + LAT));
          end
        end
      end
    end

    always @(end_ev) begin
      checkOutput($sformatf("lane%0d disp_left", g), 32'(dq.size()), 32'd0);
      checkOutput($sformatf("lane%0d cpu_left", g), 32'(cq.size()), 32'd0);
    end
  end

  // One clock of stimulus: drive, predict the grant, check it, then check the registered results.
  task automatic applyStimulus(input logic dr, input logic [15:0] da, input logic cr,
                               input logic cwe, input logic [15:0] ca, input logic [15:0] cwd);
    logic starve;
    disp_req = dr; disp_addr = da;
    cpu_req = cr; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cwd;
    #1;
    starve   = (m_wait >= 8'(LIMIT));
    exp_cack = cr && (!dr || starve);
    exp_dack = dr && !exp_cack;
    -> ack_ev;
    p_disp = exp_dack;
    p_cpu  = exp_cack && !cwe;
    p_data = exp_cack ? model_read(ca) : model_read(da);
    p_e    = cyc + 1;
    -> push_ev;
    if (exp_cack && cwe) tb_mem[ca] = cwd;
    exp_en    = exp_cack || exp_dack;
    exp_we    = exp_cack && cwe;
    exp_addr  = exp_cack ? ca : da;
    exp_wdata = cwd;
    exp_stall = dr && !exp_dack;
    if (exp_cack || !cr)   m_wait = '0;
    else if (m_wait != 8'hFF) m_wait = m_wait + 8'd1;
    @(negedge clk);
    -> post_ev;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic doReset();
    disp_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    N_reset = 1'b0;
    #1;
    -> rst_ev;
    -> clr_ev;
    m_wait = '0;
    repeat (3) @(negedge clk);
    N_reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total_checks, bad_checks);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic       cpu_on, dp, cp, cw;
    logic [15:0] dad, cad, cwd;
    #1 N_reset = 1'b0;
    #1;
    -> rst_ev;
    repeat (2) @(negedge clk);
    N_reset = 1'b1;

    $display("[TB] display burst");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'(16'h0010 + i), 1'b0, 1'b0, '0, '0);
    idle(6);

    $display("[TB] cpu write then read");
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 16'h0200, 16'h1234);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 16'h0200, '0);
    idle(6);

    $display("[TB] starvation");
    cpu_on = 1'b1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 16'(16'h0040 + i), cpu_on, 1'b0, 16'h0305, '0);
      if (exp_cack) cpu_on = 1'b0;
    end
    idle(6);

    $display("[TB] interleaved reads");
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) applyStimulus(1'b1, 16'h0001, 1'b0, 1'b0, '0, '0);
      else            applyStimulus(1'b0, '0, 1'b1, 1'b0, 16'h0002, '0);
    end
    idle(8);

    $display("[TB] reset mid-flight");
    applyStimulus(1'b1, 16'h0050, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 16'h0051, '0);
    doReset();
    idle(6);
    applyStimulus(1'b1, 16'h0060, 1'b0, 1'b0, '0, '0);
    idle(6);

    $display("[TB] random traffic");
    dp = 1'b0; cp = 1'b0; cw = 1'b0; dad = '0; cad = '0; cwd = '0;
    for (int i = 0; i < 60; i++) begin
      if (!dp && $urandom_range(0, 1) == 1) begin
        dp = 1'b1; dad = 16'(16'h0080 + $urandom_range(0, 7));
      end
      if (!cp && $urandom_range(0, 2) == 0) begin
        cp = 1'b1; cw = 1'($urandom_range(0, 1));
        cad = 16'(16'h0080 + $urandom_range(0, 7)); cwd = 16'($urandom);
      end
      applyStimulus(dp, dad, cp, cw, cad, cwd);
      if (exp_dack) dp = 1'b0;
      if (exp_cack) cp = 1'b0;
    end
    idle(8);

    -> end_ev;
    #1;
    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
